// File: rtl/float_pkg.sv
// Shared constants, FSM state type and unpacked-float view for the float accumulator.
package float_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;
  localparam logic [31:0] FP_NINF = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } facc_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  function automatic logic is_nan(input float_t f);
    return (&f.exp) && (|f.man);
  endfunction

  function automatic logic is_inf(input float_t f);
    return (&f.exp) && !(|f.man);
  endfunction

  // Denormals carry no hidden bit; treat them as signed zero.
  function automatic float_t flush_denorm(input float_t f);
    float_t r;
    r = f;
    if (f.exp == '0) r.man = '0;
    return r;
  endfunction
endpackage

// File: rtl/float_accumulator_if.sv
// Product input and result output handshakes of the float accumulator.
interface float_accumulator_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      acc_result;
  logic [CNT_W-1:0] elem_cnt;
  logic             ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, acc_result, elem_cnt, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, acc_result, elem_cnt, ovf
  );
endinterface

// File: rtl/float_add_normalize.sv
// Leading-zero normalize, round and pack of the adder mantissa sum (combinational).
// FACC_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation toward zero.
module float_add_normalize
  import float_pkg::*;
#(
  parameter int GUARD_W = 3
) (
  input  logic                 sign_i,
  input  logic [EXP_W-1:0]     exp_i,
  input  logic [24+GUARD_W:0]  man_i,
  output logic [31:0]          res_o,
  output logic                 ovf_o
);
  localparam int W       = 25 + GUARD_W;
  localparam int EXP_MAX = 2 * EXP_BIAS;
`ifdef FACC_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic [5:0]         lz;
  logic [W-1:0]       norm;
  logic [23:0]        mant;
  logic               rnd_up;
  logic [24:0]        mant_r;
  logic signed [10:0] exp_n;
  logic signed [10:0] exp_r;

  always_comb begin
    lz = 6'(W);
    for (int i = 0; i < W; i++) begin
      if (man_i[i]) lz = 6'(W - 1 - i);
    end
  end

  // Input hidden bit sits one below the MSB, so lz==1 keeps the exponent.
  assign norm   = man_i << lz;
  assign mant   = norm[W-1 -: 24];
  assign rnd_up = RNE & norm[GUARD_W] & ((|norm[GUARD_W-1:0]) | norm[GUARD_W+1]);
  assign mant_r = {1'b0, mant} + 25'(rnd_up);
  assign exp_n  = $signed({3'b000, exp_i}) + 11'sd1 - $signed({5'b00000, lz});
  assign exp_r  = exp_n + $signed({10'd0, mant_r[24]});

  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    if (man_i == '0) begin
      res_o = '0;
    end else if (exp_r > $signed(11'(EXP_MAX))) begin
      res_o = sign_i ? FP_NINF : FP_PINF;
      ovf_o = 1'b1;
    end else if (exp_r < 11'sd1) begin
      res_o[SIGN_BIT] = sign_i;
    end else begin
      res_o = {sign_i, exp_r[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
    end
  end
endmodule

// File: rtl/float_accumulator.sv
// Running IEEE-754 single-precision sum of a product stream; one add per 4 cycles via ALIGN/ADD/NORM.
// Result after the in_last product is held on out_valid until accepted; rounding mode set by FACC_ROUND_NEAREST_EN.
module float_accumulator
  import float_pkg::*;
#(
  parameter int GUARD_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              clear,
  float_accumulator_if.slave bus
);
  localparam int M = 24 + GUARD_W;
  localparam int W = M + 1;

  facc_state_t      state_q, state_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      opnd_q, opnd_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      spec_val_q, spec_val_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q, rdy_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic             spec_q, spec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [M-1:0]     big_q, big_d;
  logic [M-1:0]     sml_q, sml_d;
  logic [W-1:0]     msum_q, msum_d;

  float_t           fa, fb, big, sml;
  logic [EXP_W-1:0] diff;
  logic [M-1:0]     big_m, sml_m, sml_sh, lost_mask;
  logic             nan_c, spec_c;
  logic [31:0]      spec_val_c;
  logic [31:0]      norm_res;
  logic             norm_ovf;
  logic             in_rdy;

  assign in_rdy        = rdy_q & EN & (state_q == IDLE);
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc_result = acc_q;
  assign bus.elem_cnt  = cnt_q;
  assign bus.ovf       = ovf_q;

  // Alignment of the running sum against the latched product.
  always_comb begin
    fa        = flush_denorm(sum_q);
    fb        = flush_denorm(opnd_q);
    big       = (fa[30:0] >= fb[30:0]) ? fa : fb;
    sml       = (fa[30:0] >= fb[30:0]) ? fb : fa;
    diff      = big.exp - sml.exp;
    big_m     = {big.exp != '0, big.man, {GUARD_W{1'b0}}};
    sml_m     = {sml.exp != '0, sml.man, {GUARD_W{1'b0}}};
    lost_mask = ~({M{1'b1}} << diff);
    if (int'(diff) >= M) begin
      sml_sh = {{(M-1){1'b0}}, |sml_m};
    end else begin
      sml_sh = (sml_m >> diff) | {{(M-1){1'b0}}, |(sml_m & lost_mask)};
    end
    nan_c      = is_nan(sum_q) | is_nan(opnd_q) |
                 (is_inf(sum_q) & is_inf(opnd_q) & (sum_q[SIGN_BIT] ^ opnd_q[SIGN_BIT]));
    spec_c     = nan_c | is_inf(sum_q) | is_inf(opnd_q);
    spec_val_c = nan_c ? FP_QNAN : (is_inf(sum_q) ? sum_q : opnd_q);
  end

  float_add_normalize #(.GUARD_W(GUARD_W)) u_norm (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .man_i  (msum_q),
    .res_o  (norm_res),
    .ovf_o  (norm_ovf)
  );

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    spec_val_d = spec_val_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    rdy_d      = 1'b1;
    sign_d     = sign_q;
    sub_d      = sub_q;
    spec_d     = spec_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    big_d      = big_q;
    sml_d      = sml_q;
    msum_d     = msum_q;
    if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            sum_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
          end else if (bus.in_valid && in_rdy) begin
            opnd_d  = bus.in_data;
            last_d  = bus.in_last;
            state_d = ALIGN;
          end
        end
        ALIGN: begin
          big_d      = big_m;
          sml_d      = sml_sh;
          exp_d      = big.exp;
          sign_d     = big.sign;
          sub_d      = big.sign ^ sml.sign;
          spec_d     = spec_c;
          spec_val_d = spec_val_c;
          state_d    = ADD;
        end
        ADD: begin
          msum_d  = sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
          state_d = NORM;
        end
        NORM: begin
          sum_d = spec_q ? spec_val_q : norm_res;
          ovf_d = ovf_q | (~spec_q & norm_ovf);
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (last_q) begin
            acc_d   = sum_d;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      spec_val_q <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rdy_q      <= 1'b0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      spec_q     <= 1'b0;
      cnt_q      <= '0;
      exp_q      <= '0;
      big_q      <= '0;
      sml_q      <= '0;
      msum_q     <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      spec_val_q <= spec_val_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      rdy_q      <= rdy_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      spec_q     <= spec_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      big_q      <= big_d;
      sml_q      <= sml_d;
      msum_q     <= msum_d;
    end
  end
endmodule

// File: tb/tb_float_accumulator.sv
// Directed-vector bench for float_accumulator with hand-computed IEEE-754 results.
`timescale 1ns/1ps
module tb_float_accumulator;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic EN    = 1'b1;
  logic clear = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  float_accumulator_if #(.CNT_W(16)) bus ();

  float_accumulator #(.GUARD_W(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .EN    (EN),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk1({tag, "_rdy"}, bus.in_ready, 1'b1);
  endtask

  // Returns just after the accept edge (DUT then in ALIGN).
  task automatic send(input string tag, input logic [31:0] d, input logic l);
    wait_rdy(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int lat, input logic [31:0] res,
                               input logic [15:0] cnt, input logic ov);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk32({tag, "_lat"}, 32'(k), 32'(lat));
    chk32({tag, "_res"}, bus.acc_result, res);
    chk32({tag, "_cnt"}, {16'd0, bus.elem_cnt}, {16'd0, cnt});
    chk1({tag, "_ovf"}, bus.ovf, ov);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk32({tag, "_after"}, {14'd0, bus.out_valid, bus.ovf, bus.elem_cnt}, 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk32("rst_acc", bus.acc_result, 32'h0);
    chk32("rst_cnt", {16'd0, bus.elem_cnt}, 32'd0);
    chk1("rst_ovf", bus.ovf, 1'b0);
    chk1("rst_oval", bus.out_valid, 1'b0);
    chk1("rst_rdy", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rdy_before_edge", bus.in_ready, 1'b0);
    step();
    chk1("rdy_idle", bus.in_ready, 1'b1);

    // 2.0 + 3.0 = 5.0
    send("add23a", 32'h40000000, 1'b0);
    chk1("rdy_align", bus.in_ready, 1'b0);
    send("add23b", 32'h40400000, 1'b1);
    expect_result("add23", 3, 32'h40A00000, 16'd2, 1'b0);

    send("neg", 32'hC1326666, 1'b1);
    expect_result("neg", 3, 32'hC1326666, 16'd1, 1'b0);

    send("cancel_a", 32'h3F800000, 1'b0);
    send("cancel_b", 32'hBF800000, 1'b1);
    expect_result("cancel", 3, 32'h00000000, 16'd2, 1'b0);

    // 3.0 + -1.0 = 2.0 (exponent difference, subtract)
    send("sub_a", 32'h40400000, 1'b0);
    send("sub_b", 32'hBF800000, 1'b1);
    expect_result("sub", 3, 32'h40000000, 16'd2, 1'b0);

    send("inf_a", 32'h7F800000, 1'b0);
    send("inf_b", 32'hFF800000, 1'b1);
    expect_result("inf", 3, 32'h7FC00000, 16'd2, 1'b0);

    send("nan", 32'h7F800001, 1'b1);
    expect_result("nan", 3, 32'h7FC00000, 16'd1, 1'b0);

    send("denorm", 32'h00400000, 1'b1);
    expect_result("denorm", 3, 32'h00000000, 16'd1, 1'b0);

    // min normal minus (min normal + 1 ulp) underflows to -0
    send("ufl_a", 32'h00800000, 1'b0);
    send("ufl_b", 32'h80800001, 1'b1);
    expect_result("ufl", 3, 32'h80000000, 16'd2, 1'b0);

    send("ovf_a", 32'h7F7FFFFF, 1'b0);
    send("ovf_b", 32'h7F7FFFFF, 1'b1);
    expect_result("ovf", 3, 32'h7F800000, 16'd2, 1'b1);

    // clear beats in_valid in IDLE
    send("clr_a", 32'h40000000, 1'b0);
    wait_rdy("clr_w");
    chk32("clr_cnt_pre", {16'd0, bus.elem_cnt}, 32'd1);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40400000;
    bus.in_last  = 1'b1;
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk1("clr_idle", bus.in_ready, 1'b1);
    chk32("clr_cnt", {16'd0, bus.elem_cnt}, 32'd0);
    send("clr_b", 32'h3F800000, 1'b1);
    expect_result("clr", 3, 32'h3F800000, 16'd1, 1'b0);

    // EN low for 3 cycles while in ADD
    send("en_a", 32'h40000000, 1'b0);
    send("en_b", 32'h40400000, 1'b1);
    step();
    EN = 1'b0;
    chk1("en_rdy", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("en_hold_oval", bus.out_valid, 1'b0);
      chk32("en_hold_cnt", {16'd0, bus.elem_cnt}, 32'd1);
    end
    EN = 1'b1;
    expect_result("en", 2, 32'h40A00000, 16'd2, 1'b0);

    // Backpressure on the result
    send("bp", 32'h40000000, 1'b1);
    for (int k = 0; k < 40 && bus.out_valid !== 1'b1; k++) step();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_oval", bus.out_valid, 1'b1);
      chk32("bp_res", bus.acc_result, 32'h40000000);
      chk1("bp_rdy", bus.in_ready, 1'b0);
      step();
    end
    EN = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk1("bp_en0_hold", bus.out_valid, 1'b1);
    EN = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk1("bp_taken", bus.out_valid, 1'b0);

    // Reset during ALIGN of the next group
    send("rst_mid", 32'h40400000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk32("rstm_acc", bus.acc_result, 32'h0);
    chk32("rstm_cnt", {16'd0, bus.elem_cnt}, 32'd0);
    chk1("rstm_ovf", bus.ovf, 1'b0);
    chk1("rstm_oval", bus.out_valid, 1'b0);
    chk1("rstm_rdy", bus.in_ready, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("rstm_no_partial", bus.out_valid, 1'b0);
    end
    chk32("rstm_acc_end", bus.acc_result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
